// File: rtl/imem_arbiter.sv
// imem_arbiter: two-requester arbiter (CPU read/write, crypto-engine DMA
// read-only) in front of a single-port synchronous instruction memory.
// Each access takes a grant cycle (memory address driven combinationally)
// followed by a one-cycle response pulse to the granted requester.
// Accesses outside [MEM_BASE, MEM_BASE + 4*2^MEM_AW) never touch memory
// and complete with zero data and a range_err pulse.
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   -> simultaneous requests alternate against last_grant
//   undefined -> CPU wins every tie (fixed priority)
module imem_arbiter #(
  parameter logic [31:0] MEM_BASE = 32'h00010000,
  parameter int          MEM_AW   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_valid,
  input  logic [31:0]       dma_addr,
  output logic              dma_ready,
  output logic [31:0]       dma_rdata,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  output logic              range_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESP_CPU = 2'd1,
    RESP_DMA = 2'd2
  } state_t;

  // last_grant encoding
  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DMA = 1'b1;

  // Window size in bytes, one bit wider than the address so it cannot wrap.
  localparam logic [32:0] WIN_BYTES = 33'd4 << MEM_AW;

  state_t      state_r;
  logic        last_grant_r;
  logic        cpu_resp_r;
  logic        dma_resp_r;
  logic        err_r;

  logic        any_valid_s;
  logic        grant_dma_s;
  logic        grant_s;
  logic [31:0] sel_addr_s;
  logic [31:0] offset_s;
  logic        in_range_s;
  logic        write_s;

  // Arbitration decision and range check for the request seen in IDLE.
  always_comb begin
    any_valid_s = cpu_valid | dma_valid;
    if (cpu_valid && dma_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_dma_s = (last_grant_r == GRANT_CPU);
`else
      grant_dma_s = 1'b0;
`endif
    end else if (dma_valid) begin
      grant_dma_s = 1'b1;
    end else begin
      grant_dma_s = 1'b0;
    end
    sel_addr_s = grant_dma_s ? dma_addr : cpu_addr;
    offset_s   = sel_addr_s - MEM_BASE;
    in_range_s = ({1'b0, offset_s} < WIN_BYTES);
    grant_s    = (state_r == IDLE) && any_valid_s && !rst;
    // Only an in-range CPU access with non-zero strobes writes memory.
    write_s    = grant_s && !grant_dma_s && in_range_s && (cpu_wstrb != 4'b0000);
  end

  // Memory port: address and write strobe are only live in the grant cycle.
  always_comb begin
    if (grant_s) begin
      mem_addr = sel_addr_s[MEM_AW+1:2];
    end else begin
      mem_addr = {MEM_AW{1'b0}};
    end
    if (write_s) begin
      mem_we    = 1'b1;
      mem_wdata = cpu_wdata;
      mem_wstrb = cpu_wstrb;
    end else begin
      mem_we    = 1'b0;
      mem_wdata = 32'h0000_0000;
      mem_wstrb = 4'b0000;
    end
  end

  // Arbiter FSM: grant in IDLE, one response cycle, then back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_DMA;
      cpu_resp_r   <= 1'b0;
      dma_resp_r   <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_valid_s) begin
            state_r      <= grant_dma_s ? RESP_DMA : RESP_CPU;
            last_grant_r <= grant_dma_s ? GRANT_DMA : GRANT_CPU;
            cpu_resp_r   <= !grant_dma_s;
            dma_resp_r   <= grant_dma_s;
            err_r        <= !in_range_s;
          end else begin
            cpu_resp_r <= 1'b0;
            dma_resp_r <= 1'b0;
            err_r      <= 1'b0;
          end
        end
        RESP_CPU, RESP_DMA: begin
          state_r    <= IDLE;
          cpu_resp_r <= 1'b0;
          dma_resp_r <= 1'b0;
          err_r      <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          cpu_resp_r <= 1'b0;
          dma_resp_r <= 1'b0;
          err_r      <= 1'b0;
        end
      endcase
    end
  end

  // Response outputs; a reset landing in the response cycle suppresses it.
  always_comb begin
    cpu_ready = cpu_resp_r && !rst;
    dma_ready = dma_resp_r && !rst;
    range_err = err_r && !rst && (cpu_resp_r || dma_resp_r);
    if (cpu_ready && !err_r) begin
      cpu_rdata = mem_rdata;
    end else begin
      cpu_rdata = 32'h0000_0000;
    end
    if (dma_ready && !err_r) begin
      dma_rdata = mem_rdata;
    end else begin
      dma_rdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: stimulus tasks push expected responses,
// a negedge monitor pops and compares whenever a ready is seen.
module tb_imem_arbiter;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_valid = 1'b0;
  logic [31:0]   cpu_addr = 32'h0;
  logic [31:0]   cpu_wdata = 32'h0;
  logic [3:0]    cpu_wstrb = 4'h0;
  logic          cpu_ready;
  logic [31:0]   cpu_rdata;
  logic          dma_valid = 1'b0;
  logic [31:0]   dma_addr = 32'h0;
  logic          dma_ready;
  logic [31:0]   dma_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_rdata = 32'h0;
  logic          range_err;

  imem_arbiter #(.MEM_BASE(32'h00010000), .MEM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_ready(dma_ready),
    .dma_rdata(dma_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  // Synchronous memory model: read returns old contents one cycle later.
  logic [31:0] mem [0:(1<<AW)-1];
  int we_cnt = 0;
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct packed {
    logic        is_dma;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: both readys exclusive, idle rdata zero, responses match queue.
  always @(negedge clk) begin
    exp_t e;
    if (cpu_ready && dma_ready) chk("both_ready", 32'd1, 32'd0);
    if (!cpu_ready && cpu_rdata !== 32'h0) chk("cpu_rdata_idle", cpu_rdata, 32'h0);
    if (!dma_ready && dma_rdata !== 32'h0) chk("dma_rdata_idle", dma_rdata, 32'h0);
    if (cpu_ready || dma_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_requester", {31'd0, dma_ready}, {31'd0, e.is_dma});
        chk("resp_rdata", dma_ready ? dma_rdata : cpu_rdata, e.rdata);
        chk("resp_err", {31'd0, range_err}, {31'd0, e.err});
      end
    end
  end

  // One isolated request; checks grant-cycle memory port and latency.
  task automatic do_req(input logic is_dma, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [31:0] exp_maddr, input logic exp_we);
    int cyc;
    logic got;
    logic rdy;
    logic [31:0] c_addr, c_wdata;
    logic c_we;
    logic [3:0] c_wstrb;
    int we0;
    exp_q.push_back('{is_dma, exp_rdata, exp_err});
    @(posedge clk); #1;
    we0 = we_cnt;
    if (is_dma) begin
      dma_valid = 1'b1; dma_addr = addr;
    end else begin
      cpu_valid = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
    end
    cyc = 0; got = 1'b0;
    c_addr = 32'h0; c_we = 1'b0; c_wstrb = 4'h0; c_wdata = 32'h0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      rdy = is_dma ? dma_ready : cpu_ready;
      if (rdy) got = 1'b1;
      else begin
        c_addr = {{(32-AW){1'b0}}, mem_addr}; c_we = mem_we;
        c_wstrb = mem_wstrb; c_wdata = mem_wdata;
      end
    end
    chk("ready_seen", {31'd0, got}, 32'd1);
    chk("latency", cyc, 32'd2);
    chk("grant_mem_addr", c_addr, exp_maddr);
    chk("grant_mem_we", {31'd0, c_we}, {31'd0, exp_we});
    if (exp_we) begin
      chk("grant_mem_wstrb", {28'd0, c_wstrb}, {28'd0, wstrb});
      chk("grant_mem_wdata", c_wdata, wdata);
    end
    @(posedge clk); #1;
    cpu_valid = 1'b0; dma_valid = 1'b0; cpu_wstrb = 4'h0;
    chk("we_pulses", we_cnt - we0, exp_we ? 32'd1 : 32'd0);
  endtask

  initial begin
    int n, cyc;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    mem[16]    = 32'hDEADBEEF;
    mem[1]     = 32'hAABBCCDD;
    mem[16383] = 32'h5555AAAA;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_dma_ready", {31'd0, dma_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_range_err", {31'd0, range_err}, 32'd0);
    chk("rst_mem_addr", {18'd0, mem_addr}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("idle_mem_we", {31'd0, mem_we}, 32'd0);

    // CPU read, CPU write, read-back with byte strobes
    do_req(1'b0, 32'h00010040, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 32'd16, 1'b0);
    do_req(1'b0, 32'h00010004, 32'h12345678, 4'b0011, 32'hAABBCCDD, 1'b0, 32'd1, 1'b1);
    do_req(1'b0, 32'h00010004, 32'h0, 4'h0, 32'hAABB5678, 1'b0, 32'd1, 1'b0);
    // Window edges: last word in range, words just outside either side
    do_req(1'b0, 32'h0001FFFC, 32'h0, 4'h0, 32'h5555AAAA, 1'b0, 32'd16383, 1'b0);
    do_req(1'b0, 32'h0000FFFC, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 32'd16383, 1'b0);
    do_req(1'b0, 32'h00020000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 32'd0, 1'b0);
    // DMA reads: in range, then out of range
    do_req(1'b1, 32'h00010040, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 32'd16, 1'b0);
    do_req(1'b1, 32'h00020000, 32'h0, 4'h0, 32'h0, 1'b1, 32'd0, 1'b0);
    chk("mem1_unchanged_by_oob", mem[1], 32'hAABB5678);

    // Reset in RESP_DMA aborts, held request is re-granted
    exp_q.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
    @(posedge clk); #1; dma_valid = 1'b1; dma_addr = 32'h00010040;
    @(negedge clk);
    chk("abort_grant_addr", {18'd0, mem_addr}, 32'd16);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("abort_no_dma_ready", {31'd0, dma_ready}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    cyc = 0;
    while (!dma_ready && cyc < 20) begin @(negedge clk); cyc++; end
    chk("regrant_latency", cyc, 32'd2);
    @(posedge clk); #1; dma_valid = 1'b0;

    // Simultaneous requests held for 8 transactions
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 8; i++)
      exp_q.push_back((i % 2 == 0) ? exp_t'('{1'b0, 32'hDEADBEEF, 1'b0})
                                   : exp_t'('{1'b1, 32'hAABB5678, 1'b0}));
`else
    for (int i = 0; i < 8; i++) exp_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
    exp_q.push_back('{1'b1, 32'hAABB5678, 1'b0});
`endif
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_addr = 32'h00010040; cpu_wstrb = 4'h0;
    dma_valid = 1'b1; dma_addr = 32'h00010004;
    n = 0; cyc = 0;
    while (n < 8 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (cpu_ready || dma_ready) n++;
    end
    chk("tie_count", n, 32'd8);
    chk("tie_cycles", cyc, 32'd16);
    @(posedge clk); #1; cpu_valid = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    dma_valid = 1'b0;
`else
    cyc = 0;
    while (!dma_ready && cyc < 20) begin @(negedge clk); cyc++; end
    chk("dma_after_cpu_latency", cyc, 32'd2);
    @(posedge clk); #1; dma_valid = 1'b0;
`endif
    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
